// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types for the IF/ID stage.
//   word_t        : default 32-bit machine word
//   if_id_entry_t : {npc, instr, side} record handed from fetch to decode
//   NOP_INSTR     : value decode sees when the stage holds nothing
//   ptr_w()       : pointer width for a circular buffer of a given depth
package cpu_types_pkg;

  localparam int unsigned WORD_W_DFLT = 32;

  typedef logic [WORD_W_DFLT-1:0] word_t;

  typedef struct packed {
    word_t npc;
    word_t instr;
    logic  side;
  } if_id_entry_t;

  localparam word_t NOP_INSTR = '0;

  // A one-entry buffer still needs a 1-bit pointer port, even though it stays 0.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/if_id_ctrl.sv
// if_id_ctrl: read/write pointers, entry count and registered in_ready
// for the IF/ID elastic buffer.
// Ports:
//   CLK, nRST          clock, async active-low reset
//   in_valid           fetch offers an entry
//   out_ready          decode takes the head entry
//   flush              squash everything held (wins over push/pop)
//   push, pop          qualified handshakes for the datapath
//   in_ready           registered "room available"
//   out_valid          head entry valid
//   wr_ptr, rd_ptr     circular-buffer pointers
//   count              number of held entries
module if_id_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic                             in_valid,
  input  logic                             out_ready,
  input  logic                             flush,
  output logic                             push,
  output logic                             pop,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [ptr_w(DEPTH)-1:0]          wr_ptr,
  output logic [ptr_w(DEPTH)-1:0]          rd_ptr,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q, in_ready_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    // Ready is taken from the next-state count so fetch never sees decode's
    // out_ready combinationally; a pop on full reopens the input one cycle late.
    in_ready_d = (count_d < FULL_CNT);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign wr_ptr   = wr_ptr_q;
  assign rd_ptr   = rd_ptr_q;
  assign count    = count_q;

endmodule

// File: rtl/if_id_elastic_latch.sv
// if_id_elastic_latch: IF/ID pipeline register as a valid/ready elastic
// buffer of DEPTH entries with flush and a registered in_ready.
// Ports:
//   CLK, nRST                      clock, async active-low reset
//   in_valid/in_ready              fetch-side handshake
//   in_npc, in_instr, in_side      entry captured on push
//   flush                          squash all held entries
//   out_valid/out_ready            decode-side handshake
//   out_npc, out_instr, out_side   head entry, zero when empty
//   occupancy                      number of held entries
// Optional (macro IF_ID_PERF_CNT_EN):
//   stall_cycles                   cycles fetch was held off by in_ready
//   flush_drops                    entries squashed by flushes
module if_id_elastic_latch
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned SIDE_W = 1,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_W-1:0]          in_npc,
  input  logic [WORD_W-1:0]          in_instr,
  input  logic [SIDE_W-1:0]          in_side,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_W-1:0]          out_npc,
  output logic [WORD_W-1:0]          out_instr,
  output logic [SIDE_W-1:0]          out_side,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]                stall_cycles,
  output logic [31:0]                flush_drops
`endif
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = 2 * WORD_W + SIDE_W;

  logic             push, pop;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [ENT_W-1:0] head;

  if_id_ctrl #(
    .DEPTH(DEPTH)
  ) u_ctrl (
    .CLK      (CLK),
    .nRST     (nRST),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .flush    (flush),
    .push     (push),
    .pop      (pop),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (count)
  );

  always_comb begin
    mem_d = mem_q;
    // A push that coincides with flush is dropped rather than written.
    if (push && !flush) mem_d[wr_ptr] = {in_npc, in_instr, in_side};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign head      = mem_q[rd_ptr];
  assign out_npc   = out_valid ? head[ENT_W-1 -: WORD_W]        : '0;
  assign out_instr = out_valid ? head[SIDE_W +: WORD_W]         : WORD_W'(NOP_INSTR);
  assign out_side  = out_valid ? head[SIDE_W-1:0]               : '0;
  assign occupancy = count;

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_drops_q, flush_drops_d;
  logic [32:0] drop_sum;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_drops_d  = flush_drops_q;
    drop_sum       = {1'b0, flush_drops_q} + 33'(count) + 33'(push);
    if (in_valid && !in_ready && !flush && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 32'd1;
    if (flush)
      flush_drops_d = drop_sum[32] ? '1 : drop_sum[31:0];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles_q <= '0;
      flush_drops_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_drops_q  <= flush_drops_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_drops  = flush_drops_q;
`endif

endmodule

// File: tb/tb_if_id_elastic_latch.sv
// Bench for if_id_elastic_latch: a DEPTH=2 and a DEPTH=3 instance share the
// same stimulus; each is compared to its own queue-based reference model.
module tb_if_id_elastic_latch;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_npc = '0;
  logic [31:0] in_instr = '0;
  logic [0:0]  in_side = '0;

  logic        rdy   [2];
  logic        vld   [2];
  logic [31:0] o_npc [2];
  logic [31:0] o_ins [2];
  logic [0:0]  o_sid [2];
  logic [1:0]  occ   [2];

  int unsigned  dep [2] = '{2, 3};
  if_id_entry_t mq  [2][$];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  if_id_elastic_latch #(.WORD_W(32), .SIDE_W(1), .DEPTH(2)) u_d2 (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_npc(in_npc), .in_instr(in_instr), .in_side(in_side), .flush(flush),
    .out_valid(vld[0]), .out_ready(out_ready), .out_npc(o_npc[0]),
    .out_instr(o_ins[0]), .out_side(o_sid[0]), .occupancy(occ[0])
  );

  if_id_elastic_latch #(.WORD_W(32), .SIDE_W(1), .DEPTH(3)) u_d3 (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_npc(in_npc), .in_instr(in_instr), .in_side(in_side), .flush(flush),
    .out_valid(vld[1]), .out_ready(out_ready), .out_npc(o_npc[1]),
    .out_instr(o_ins[1]), .out_side(o_sid[1]), .occupancy(occ[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, compare outputs with the model, then advance
  // each model by the handshake rules for the coming clock edge.
  task automatic step(input logic iv, input logic [31:0] npc, input logic [31:0] instr,
                      input logic sd, input logic fl, input logic ordy);
    if_id_entry_t e;
    logic         ev, er;
    @(negedge CLK);
    in_valid  = iv;
    in_npc    = npc;
    in_instr  = instr;
    in_side   = sd;
    flush     = fl;
    out_ready = ordy;
    #1;
    for (int k = 0; k < 2; k++) begin
      ev = (mq[k].size() != 0);
      er = (mq[k].size() < dep[k]);
      e  = ev ? mq[k][0] : '0;
      chk($sformatf("d%0d_in_ready", dep[k]), 32'(rdy[k]), 32'(er));
      chk($sformatf("d%0d_out_valid", dep[k]), 32'(vld[k]), 32'(ev));
      chk($sformatf("d%0d_occupancy", dep[k]), 32'(occ[k]), 32'(mq[k].size()));
      chk($sformatf("d%0d_out_npc", dep[k]), o_npc[k], e.npc);
      chk($sformatf("d%0d_out_instr", dep[k]), o_ins[k], e.instr);
      chk($sformatf("d%0d_out_side", dep[k]), 32'(o_sid[k]), 32'(e.side));
      if (fl) begin
        mq[k].delete();
      end else begin
        if (ev && ordy) void'(mq[k].pop_front());
        if (iv && er) begin
          e.npc   = npc;
          e.instr = instr;
          e.side  = sd;
          mq[k].push_back(e);
        end
      end
    end
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, ordy);
  endtask

  initial begin
    // Power-on reset.
    @(negedge CLK);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d_por_in_ready", dep[k]), 32'(rdy[k]), 32'd1);
      chk($sformatf("d%0d_por_occupancy", dep[k]), 32'(occ[k]), 32'd0);
    end
    @(negedge CLK);
    nRST = 1'b1;

    // Single transfer, held while decode stalls, then popped.
    step(1'b1, 32'h0000_0004, 32'h2002_0005, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 3);
    idle(1'b1, 2);

    // Fill and backpressure; the third entry waits on in_ready.
    step(1'b1, 32'h100, 32'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h104, 32'h22, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h108, 32'h33, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h108, 32'h33, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h108, 32'h33, 1'b0, 1'b0, 1'b1);
    idle(1'b1, 4);

    // Asynchronous reset mid-stream with both buffers holding entries.
    step(1'b1, 32'h200, 32'hAA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h204, 32'hBB, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    in_valid = 1'b0;
    nRST     = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d_rst_out_valid", dep[k]), 32'(vld[k]), 32'd0);
      chk($sformatf("d%0d_rst_out_instr", dep[k]), o_ins[k], 32'd0);
      chk($sformatf("d%0d_rst_occupancy", dep[k]), 32'(occ[k]), 32'd0);
      mq[k].delete();
    end
    @(negedge CLK);
    nRST = 1'b1;
    idle(1'b0, 1);

    // Continuous streaming of instrs 1..8.
    for (int i = 1; i <= 8; i++)
      step(1'b1, 32'(i * 4), 32'(i), 1'(i % 2), 1'b0, 1'b1);
    idle(1'b1, 3);

    // Flush beats a coinciding push and pop.
    step(1'b1, 32'h300, 32'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h304, 32'h22, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h308, 32'h33, 1'b0, 1'b1, 1'b1);
    idle(1'b1, 3);

    // Two pushes then one pop, enough to wrap both pointer rings.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h400 + 32'(i * 8), 32'h500 + 32'(2 * i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h404 + 32'(i * 8), 32'h501 + 32'(2 * i), 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    end
    idle(1'b1, 4);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom(), $urandom(),
           $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
           $urandom_range(0, 2) != 0);
    idle(1'b1, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
